// File: rtl/result_drain_if.sv
// Stream/SRAM bundle for result_drain_ctrl: control in, SRAM read port,
// and the lane-serialised valid/ready output stream.
interface result_drain_if #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int MATRIX_SIZE    = 8
);
  localparam int LANE_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

  logic                                  start;
  logic [ADDRESSSIZE-1:0]                base_addr;
  logic [ADDRESSSIZE:0]                  num_rows;
  logic                                  rd_en;
  logic [ADDRESSSIZE-1:0]                rd_addr;
  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] rd_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [PARTIAL_SUM_BW-1:0]             out_data;
  logic [LANE_W-1:0]                     out_lane;
  logic                                  out_last;
  logic                                  busy;
  logic                                  done;

  modport master (
    input  start, base_addr, num_rows, rd_data, out_ready,
    output rd_en, rd_addr, out_valid, out_data, out_lane, out_last, busy, done
  );

  modport slave (
    output start, base_addr, num_rows, rd_data, out_ready,
    input  rd_en, rd_addr, out_valid, out_data, out_lane, out_last, busy, done
  );
endinterface

// File: rtl/result_drain_ctrl.sv
// Drains a range of results-SRAM rows onto a one-lane-per-beat valid/ready stream.
// Optional `RESULT_DRAIN_RELU_EN clamps negative lanes to zero on the output.
module result_drain_ctrl #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int MATRIX_SIZE    = 8
) (
  input logic            clk,
  input logic            rst,
  result_drain_if.master bus
);
  localparam int ROW_W  = MATRIX_SIZE * PARTIAL_SUM_BW;
  localparam int LANE_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(MATRIX_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t                  state_r;
  logic [ADDRESSSIZE-1:0]  row_addr_r;
  logic [ADDRESSSIZE:0]    rows_left_r;
  logic [ROW_W-1:0]        shift_r;
  logic [LANE_W-1:0]       lane_r;
  logic                    rd_en_r;
  logic                    out_valid_r;
  logic                    out_last_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    beat_s;
  logic                    last_row_s;
  logic [LANE_W-1:0]       lane_next_s;

  function automatic logic [PARTIAL_SUM_BW-1:0] lane_out(input logic [PARTIAL_SUM_BW-1:0] v);
`ifdef RESULT_DRAIN_RELU_EN
    lane_out = v[PARTIAL_SUM_BW-1] ? {PARTIAL_SUM_BW{1'b0}} : v;
`else
    lane_out = v;
`endif
  endfunction

  assign beat_s      = out_valid_r & bus.out_ready;
  assign last_row_s  = (rows_left_r == (ADDRESSSIZE+1)'(1));
  assign lane_next_s = lane_r + LANE_W'(1);

  // Drain FSM; every output is a register so the stream holds still under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      row_addr_r  <= '0;
      rows_left_r <= '0;
      shift_r     <= '0;
      lane_r      <= '0;
      rd_en_r     <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r      <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          if (bus.start) begin
            busy_r <= 1'b1;
            if (bus.num_rows != '0) begin
              row_addr_r  <= bus.base_addr;
              rows_left_r <= bus.num_rows;
              rd_en_r     <= 1'b1;
              state_r     <= READ;
            end else begin
              rd_en_r <= 1'b0;
              state_r <= FIN;
            end
          end else begin
            busy_r  <= 1'b0;
            rd_en_r <= 1'b0;
          end
        end
        READ: begin
          rd_en_r <= 1'b0;
          state_r <= WAIT;
        end
        WAIT: begin
          shift_r     <= bus.rd_data;
          lane_r      <= '0;
          out_valid_r <= 1'b1;
          out_last_r  <= (MATRIX_SIZE == 1) && last_row_s;
          state_r     <= SEND;
        end
        SEND: begin
          if (beat_s) begin
            if (lane_r == LAST_LANE) begin
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              if (last_row_s) begin
                rows_left_r <= '0;
                done_r      <= 1'b1;
                state_r     <= FIN;
              end else begin
                // Address wraps naturally at 2^ADDRESSSIZE; that is a legal range.
                rows_left_r <= rows_left_r - (ADDRESSSIZE+1)'(1);
                row_addr_r  <= row_addr_r + ADDRESSSIZE'(1);
                rd_en_r     <= 1'b1;
                state_r     <= READ;
              end
            end else begin
              shift_r    <= shift_r >> PARTIAL_SUM_BW;
              lane_r     <= lane_next_s;
              out_last_r <= (lane_next_s == LAST_LANE) && last_row_s;
            end
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        FIN: begin
          // Zero-length requests arrive with done low and spend one extra cycle here.
          if (done_r) begin
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            done_r <= 1'b1;
          end
        end
        default: begin
          rd_en_r     <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_en     = rd_en_r;
  assign bus.rd_addr   = row_addr_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = lane_out(shift_r[PARTIAL_SUM_BW-1:0]);
  assign bus.out_lane  = lane_r;
  assign bus.out_last  = out_last_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_result_drain_ctrl.sv
// Randomised bench for result_drain_ctrl against a queue-based transfer model.
module tb_result_drain_ctrl;
  localparam int AW  = 10;
  localparam int PSB = 20;
  localparam int MS  = 8;
  localparam int NROWS = 1 << AW;

  typedef struct {
    logic [PSB-1:0] data;
    int             lane;
    bit             last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_drain_if #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(PSB), .MATRIX_SIZE(MS)) rif ();

  result_drain_ctrl #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(PSB), .MATRIX_SIZE(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rif.master)
  );

  logic [MS*PSB-1:0] mem [NROWS];
  beat_t beat_q[$];
  int    rd_q[$];
  beat_t e;

  int checks = 0;
  int errors = 0;
  int n_neg = 0, start_neg = 0, exp_done_neg = -1, row_end_neg = 0;
  bit pend_start = 0, pend_zero = 0, first_seen = 0, need_gap = 0;
  bit xfer_open = 0, xfer_done = 0, ready_rnd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PSB-1:0] model_lane(input logic [PSB-1:0] v);
`ifdef RESULT_DRAIN_RELU_EN
    return ($signed(v) < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic load_model(input int base, input int n);
    beat_t b;
    for (int r = 0; r < n; r++) begin
      int addr;
      addr = (base + r) % NROWS;
      rd_q.push_back(addr);
      for (int l = 0; l < MS; l++) begin
        b.data = model_lane(mem[addr][l*PSB +: PSB]);
        b.lane = l;
        b.last = (r == n - 1) && (l == MS - 1);
        beat_q.push_back(b);
      end
    end
  endtask

  task automatic clear_model();
    beat_q.delete();
    rd_q.delete();
    xfer_open = 0;
    pend_start = 0;
    need_gap = 0;
    exp_done_neg = -1;
  endtask

  // SRAM: data appears the cycle after rd_en
  always @(posedge clk) begin
    if (rif.rd_en) rif.rd_data <= mem[rif.rd_addr];
  end

  initial begin
    rif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rif.out_ready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare every observed cycle with the model's expectations
  always @(negedge clk) begin
    if (!rst) begin
      n_neg++;
      if (pend_start) begin
        start_neg  = n_neg;
        pend_start = 0;
        first_seen = 0;
        need_gap   = 0;
        xfer_open  = 1;
        if (pend_zero) exp_done_neg = n_neg + 2;
      end
      if (rif.rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else check("rd_addr", 32'(rif.rd_addr), 32'(rd_q.pop_front()));
      end
      if (rif.out_valid) begin
        if (beat_q.size() == 0) check("beat_unexpected", 32'd1, 32'd0);
        else begin
          e = beat_q[0];
          check("out_data", 32'(rif.out_data), 32'(e.data));
          check("out_lane", 32'(rif.out_lane), 32'(e.lane));
          check("out_last", 32'(rif.out_last), 32'(e.last));
          if (!first_seen) begin
            check("first_latency", 32'(n_neg - start_neg), 32'd3);
            first_seen = 1;
          end
          if (need_gap && e.lane == 0) begin
            check("row_gap", 32'(n_neg - row_end_neg), 32'd3);
            need_gap = 0;
          end
          if (rif.out_ready) begin
            void'(beat_q.pop_front());
            if (e.last) exp_done_neg = n_neg + 1;
            else if (e.lane == MS - 1) begin
              row_end_neg = n_neg;
              need_gap = 1;
            end
          end
        end
      end
      check("done", 32'(rif.done), 32'(n_neg == exp_done_neg));
      check("busy", 32'(rif.busy), 32'(xfer_open && (n_neg > start_neg)));
      if (n_neg == exp_done_neg) begin
        xfer_open = 0;
        xfer_done = 1;
      end
    end
  end

  task automatic do_xfer(input int base, input int n, input bit rnd, input bit inject);
    int budget;
    @(posedge clk);
    #1;
    ready_rnd     = rnd;
    rif.start     = 1'b1;
    rif.base_addr = AW'(base);
    rif.num_rows  = (AW+1)'(n);
    load_model(base, n);
    pend_zero  = (n == 0);
    pend_start = 1;
    xfer_done  = 0;
    @(posedge clk);
    #1;
    rif.start     = 1'b0;
    rif.base_addr = AW'($urandom);
    rif.num_rows  = (AW+1)'($urandom);
    budget = rnd ? n * 100 + 20 : n * 12 + 20;
    for (int i = 0; i < budget; i++) begin
      if (xfer_done) break;
      if (inject && i == 3) begin
        rif.start     = 1'b1;
        rif.base_addr = AW'(base ^ 32'h2A5);
        rif.num_rows  = (AW+1)'(3);
      end else begin
        rif.start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    rif.start = 1'b0;
    ready_rnd = 0;
    check("xfer_complete", 32'(xfer_done), 32'd1);
    check("beats_left", 32'(beat_q.size()), 32'd0);
    check("reads_left", 32'(rd_q.size()), 32'd0);
    if (!xfer_done) begin
      rst = 1'b1;
      clear_model();
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
    end
  endtask

  initial begin
    bit hit;
    rif.start     = 1'b0;
    rif.base_addr = '0;
    rif.num_rows  = '0;
    rif.rd_data   = '0;
    for (int a = 0; a < NROWS; a++)
      for (int l = 0; l < MS; l++) mem[a][l*PSB +: PSB] = PSB'($urandom);
    for (int l = 0; l < MS; l++) mem[5][l*PSB +: PSB] = PSB'(l + 1);
    mem[7][0*PSB +: PSB] = 20'hFFFFF;
    mem[7][1*PSB +: PSB] = 20'h7FFFF;
    mem[7][2*PSB +: PSB] = 20'h80000;

    repeat (3) @(negedge clk);
    check("rst_rd_en", 32'(rif.rd_en), 32'd0);
    check("rst_valid", 32'(rif.out_valid), 32'd0);
    check("rst_busy", 32'(rif.busy), 32'd0);
    check("rst_done", 32'(rif.done), 32'd0);
    check("rst_last", 32'(rif.out_last), 32'd0);
    check("rst_data", 32'(rif.out_data), 32'd0);
    #1 rst = 1'b0;

    do_xfer(5, 1, 0, 0);
    do_xfer(100, 2, 1, 0);
    do_xfer(1023, 2, 0, 0);
    do_xfer(300, 0, 0, 0);
    do_xfer(40, 3, 0, 1);
    do_xfer(7, 1, 1, 0);

    // Reset while lane 3 of a two-row transfer is on the stream
    @(posedge clk);
    #1;
    rif.start = 1'b1; rif.base_addr = AW'(5); rif.num_rows = (AW+1)'(2);
    load_model(5, 2);
    pend_zero = 0; pend_start = 1; xfer_done = 0;
    @(posedge clk);
    #1 rif.start = 1'b0;
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (rif.out_valid && rif.out_lane == 3'd3) begin
        hit = 1;
        break;
      end
    end
    check("saw_lane3", 32'(hit), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(rif.out_valid), 32'd0);
    check("arst_busy", 32'(rif.busy), 32'd0);
    check("arst_rd_en", 32'(rif.rd_en), 32'd0);
    clear_model();
    repeat (3) begin
      @(negedge clk);
      check("arst_no_done", 32'(rif.done), 32'd0);
    end
    #1 rst = 1'b0;
    do_xfer(9, 1, 1, 0);

    for (int k = 0; k < 6; k++)
      do_xfer(int'($urandom_range(0, NROWS - 1)), int'($urandom_range(1, 4)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    do_xfer(600, NROWS, 0, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
